// File: rtl/fwd_hazard_ctrl.sv
// Operand-forwarding select and load-use stall generator for the pipelined 6502 core.
// Define FWD_WB_EN to track the WB stage and forward from it (fwd_sel=3); otherwise the regfile is write-through.
module fwd_hazard_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [1:0] id_src,
    input  logic [1:0] id_dst,
    input  logic       id_load,
    input  logic       flush,
    output logic [1:0] fwd_sel,
    output logic       stall
);

    // The load flag only matters while the writer sits in EX, so MEM/WB keep just valid+dst.
    logic       ex_v;
    logic       ex_ld;
    logic [1:0] ex_dst;
    logic       mem_v;
    logic [1:0] mem_dst;
    logic       rd_en;
    logic       ex_hit;
    logic       mem_hit;
`ifdef FWD_WB_EN
    logic       wb_v;
    logic [1:0] wb_dst;
    logic       wb_hit;
`endif

    always_comb begin
        rd_en   = id_valid && (id_src != 2'd0) && !rst;
        ex_hit  = ex_v && (ex_dst != 2'd0) && (ex_dst == id_src);
        mem_hit = mem_v && (mem_dst != 2'd0) && (mem_dst == id_src);
`ifdef FWD_WB_EN
        wb_hit  = wb_v && (wb_dst != 2'd0) && (wb_dst == id_src);
`endif
        stall   = rd_en && ex_hit && ex_ld && !flush;
        fwd_sel = 2'd0;
        // Youngest writer wins; a load still in EX cannot supply data and falls through.
        if (rd_en) begin
            if (ex_hit && !ex_ld)
                fwd_sel = 2'd1;
            else if (mem_hit)
                fwd_sel = 2'd2;
`ifdef FWD_WB_EN
            else if (wb_hit)
                fwd_sel = 2'd3;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v    <= 1'b0;
            ex_ld   <= 1'b0;
            ex_dst  <= 2'd0;
            mem_v   <= 1'b0;
            mem_dst <= 2'd0;
        end else begin
            if (stall || flush) begin
                ex_v   <= 1'b0;
                ex_ld  <= 1'b0;
                ex_dst <= 2'd0;
            end else begin
                ex_v   <= id_valid;
                ex_ld  <= id_load;
                ex_dst <= id_dst;
            end
            // A flush kills what was in EX, so it never reaches MEM.
            if (flush) begin
                mem_v   <= 1'b0;
                mem_dst <= 2'd0;
            end else begin
                mem_v   <= ex_v;
                mem_dst <= ex_dst;
            end
        end
    end

`ifdef FWD_WB_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_v   <= 1'b0;
            wb_dst <= 2'd0;
        end else begin
            wb_v   <= mem_v;
            wb_dst <= mem_dst;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios, then random traffic against an in-flight list model.
// Honours FWD_WB_EN the same way the design does.
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [1:0] id_src;
    logic [1:0] id_dst;
    logic       id_load;
    logic       flush;
    logic [1:0] fwd_sel;
    logic       stall;

    int n_checks = 0;
    int n_pass   = 0;

`ifdef FWD_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif
    localparam logic [1:0] WB_SEL = WB_EN ? 2'd3 : 2'd0;

    // Model: list of in-flight writers, youngest first, with age 0=EX, 1=MEM, 2=WB.
    typedef struct {
        logic [1:0] dst;
        logic       ld;
        int         age;
    } flight_t;

    flight_t inflight[$];

    fwd_hazard_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .id_valid (id_valid),
        .id_src   (id_src),
        .id_dst   (id_dst),
        .id_load  (id_load),
        .flush    (flush),
        .fwd_sel  (fwd_sel),
        .stall    (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void model_eval(output logic [1:0] sel, output logic stl);
        sel = 2'd0;
        stl = 1'b0;
        if (rst || !id_valid || id_src == 2'd0)
            return;
        for (int i = 0; i < inflight.size(); i++) begin
            if (inflight[i].dst != id_src)
                continue;
            if (inflight[i].age == 0 && inflight[i].ld) begin
                stl = !flush;
                continue;
            end
            if (inflight[i].age == 2 && !WB_EN)
                sel = 2'd0;
            else
                sel = 2'(inflight[i].age + 1);
            break;
        end
    endfunction

    function automatic void model_advance();
        logic [1:0] s;
        logic       st;
        flight_t    nq[$];
        flight_t    e;
        model_eval(s, st);
        if (rst) begin
            inflight.delete();
            return;
        end
        for (int i = 0; i < inflight.size(); i++) begin
            e = inflight[i];
            if (flush && e.age == 0)
                continue;
            e.age = e.age + 1;
            if (e.age <= 2)
                nq.push_back(e);
        end
        if (!flush && !st && id_valid && id_dst != 2'd0) begin
            e.dst = id_dst;
            e.ld  = id_load;
            e.age = 0;
            nq.push_front(e);
        end
        inflight = nq;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [1:0] src,
                                 input logic [1:0] dst, input logic ld, input logic fl);
        rst      = r;
        id_valid = v;
        id_src   = src;
        id_dst   = dst;
        id_load  = ld;
        flush    = fl;
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] esel, input logic estl);
        @(negedge clk);
        n_checks++;
        assert (fwd_sel === esel) n_pass++;
        else begin
            $display("[TB] FAIL %s fwd_sel: got %0d expected %0d", tag, fwd_sel, esel);
            $error("[TB] %s fwd_sel check failed", tag);
        end
        n_checks++;
        assert (stall === estl) n_pass++;
        else begin
            $display("[TB] FAIL %s stall: got %0b expected %0b", tag, stall, estl);
            $error("[TB] %s stall check failed", tag);
        end
    endtask

    task automatic advance();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic [1:0] src,
                        input logic [1:0] dst, input logic ld, input logic fl,
                        input logic [1:0] esel, input logic estl);
        applyStimulus(r, v, src, dst, ld, fl);
        checkOutput(tag, esel, estl);
        advance();
    endtask

    initial begin
        logic [1:0] es;
        logic       est;
        logic       held;

        //    tag            rst v  src   dst   ld fl  sel     stall
        step("reset_hold",   1, 1, 2'd1, 2'd0, 0, 0, 2'd0,   0);
        step("reset_hold2",  1, 1, 2'd1, 2'd1, 1, 0, 2'd0,   0);
        step("post_reset",   0, 1, 2'd1, 2'd0, 0, 0, 2'd0,   0);

        step("ex_wr",        0, 1, 2'd0, 2'd2, 0, 0, 2'd0,   0);
        step("ex_fwd",       0, 1, 2'd2, 2'd0, 0, 0, 2'd1,   0);
        step("mem_fwd",      0, 1, 2'd2, 2'd0, 0, 0, 2'd2,   0);
        step("wb_after_ex",  0, 1, 2'd2, 2'd0, 0, 0, WB_SEL, 0);
        step("ex_gone",      0, 1, 2'd2, 2'd0, 0, 0, 2'd0,   0);

        step("ld_wr",        0, 1, 2'd0, 2'd1, 1, 0, 2'd0,   0);
        step("ld_stall",     0, 1, 2'd1, 2'd0, 0, 0, 2'd0,   1);
        step("ld_after",     0, 1, 2'd1, 2'd0, 0, 0, 2'd2,   0);

        step("pri_wr0",      0, 1, 2'd0, 2'd3, 0, 0, 2'd0,   0);
        step("pri_wr1",      0, 1, 2'd0, 2'd3, 0, 0, 2'd0,   0);
        step("pri_fwd",      0, 1, 2'd3, 2'd0, 0, 0, 2'd1,   0);
        step("invalid_id",   0, 0, 2'd3, 2'd0, 0, 0, 2'd0,   0);

        step("wb_wr",        0, 1, 2'd0, 2'd1, 0, 0, 2'd0,   0);
        step("wb_nop1",      0, 1, 2'd0, 2'd0, 0, 0, 2'd0,   0);
        step("wb_nop2",      0, 1, 2'd0, 2'd0, 0, 0, 2'd0,   0);
        step("wb_path",      0, 1, 2'd1, 2'd0, 0, 0, WB_SEL, 0);

        step("fl_wr",        0, 1, 2'd0, 2'd2, 1, 0, 2'd0,   0);
        step("fl_stall",     0, 1, 2'd2, 2'd0, 0, 1, 2'd0,   0);
        step("fl_killed",    0, 1, 2'd2, 2'd0, 0, 0, 2'd0,   0);

        step("flm_wr",       0, 1, 2'd0, 2'd2, 0, 0, 2'd0,   0);
        step("flm_nop",      0, 1, 2'd0, 2'd0, 0, 0, 2'd0,   0);
        step("flm_flush",    0, 1, 2'd0, 2'd0, 0, 1, 2'd0,   0);
        step("flm_done",     0, 1, 2'd2, 2'd0, 0, 0, WB_SEL, 0);

        step("rst_wr",       0, 1, 2'd0, 2'd1, 0, 0, 2'd0,   0);
        step("rst_mid",      1, 1, 2'd1, 2'd0, 0, 0, 2'd0,   0);
        step("rst_clear",    0, 1, 2'd1, 2'd0, 0, 0, 2'd0,   0);

        // Random traffic; a stalled instruction is re-presented unchanged, as the fetch side would.
        held = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (!held) begin
                id_valid = ($urandom_range(0, 9) < 8);
                id_src   = 2'($urandom_range(0, 3));
                id_dst   = 2'($urandom_range(0, 3));
                id_load  = ($urandom_range(0, 9) < 3);
            end
            rst   = ($urandom_range(0, 59) == 0);
            flush = ($urandom_range(0, 9) == 0);
            model_eval(es, est);
            checkOutput("random", es, est);
            held = est;
            advance();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
